// File: rtl/half_adder_gate_level_pkg.sv
// Shared constants for the gate-level half adder bank.
// No latency or backpressure of its own: constants only.
// Consumers import this package to pick up default and legal lane counts.
package half_adder_gate_level_pkg;

    localparam int HA_DEFAULT_WIDTH = 1;
    localparam int HA_MIN_WIDTH     = 1;
    localparam int HA_MAX_WIDTH     = 64;

endpackage : half_adder_gate_level_pkg

// File: rtl/half_adder_cell.sv
// One-bit half adder built from one xor and one and primitive.
// Latency: zero cycles, gate delta delays only.
// Backpressure: none, the outputs always follow a and b.
module half_adder_cell (
    output wire logic s,
    output wire logic c,
    input  wire logic a,
    input  wire logic b
);

    xor u_xor (s, a, b);
    and u_and (c, a, b);

endmodule : half_adder_cell

// File: rtl/half_adder_gate_level.sv
// Bank of WIDTH independent half adders plus a registered copy of sum/carry.
// Latency: s/c are combinational, s_q/c_q are exactly one clk cycle behind.
// Backpressure: none; s_q/c_q load every rising edge, zeros while rst_n is low.
module half_adder_gate_level
    import half_adder_gate_level_pkg::*;
#(
    parameter int WIDTH = HA_DEFAULT_WIDTH
) (
    output wire logic [WIDTH-1:0] s,
    output wire logic [WIDTH-1:0] c,
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    input  wire logic             clk,
    input  wire logic             rst_n,
    output logic      [WIDTH-1:0] s_q,
    output logic      [WIDTH-1:0] c_q
);

    // Lanes never talk to each other, so an X on one input stays in its lane.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_cell u_cell (
            .s (s[i]),
            .c (c[i]),
            .a (a[i]),
            .b (b[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q <= '0;
            c_q <= '0;
        end else begin
            s_q <= s;
            c_q <= c;
        end
    end

endmodule : half_adder_gate_level

// File: tb/tb_half_adder_gate_level.sv
// Self-checking bench for half_adder_gate_level at WIDTH 1, 4 and 8.
module tb_half_adder_gate_level;

    logic       clk;
    logic       rst_n;

    logic [0:0] a1, b1;
    wire  [0:0] s1, c1;
    logic [0:0] s_q1, c_q1;

    logic [3:0] a4, b4;
    wire  [3:0] s4, c4;
    logic [3:0] s_q4, c_q4;

    logic [7:0] a8, b8;
    wire  [7:0] s8, c8;
    logic [7:0] s_q8, c_q8;

    int n_checks;
    int n_errors;

    typedef struct {
        logic a;
        logic b;
        logic s;
        logic c;
    } vec_t;

    typedef struct packed {
        logic [7:0] s;
        logic [7:0] c;
    } exp_t;

    vec_t tt[4];
    exp_t sb_q[$];

    half_adder_gate_level #(.WIDTH(1)) dut1 (
        .s(s1), .c(c1), .a(a1), .b(b1), .clk(clk), .rst_n(rst_n), .s_q(s_q1), .c_q(c_q1)
    );
    half_adder_gate_level #(.WIDTH(4)) dut4 (
        .s(s4), .c(c4), .a(a4), .b(b4), .clk(clk), .rst_n(rst_n), .s_q(s_q4), .c_q(c_q4)
    );
    half_adder_gate_level #(.WIDTH(8)) dut8 (
        .s(s8), .c(c8), .a(a8), .b(b8), .clk(clk), .rst_n(rst_n), .s_q(s_q8), .c_q(c_q8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        n_checks = 0;
        n_errors = 0;

        tt[0] = '{a: 1'b0, b: 1'b0, s: 1'b0, c: 1'b0};
        tt[1] = '{a: 1'b1, b: 1'b0, s: 1'b1, c: 1'b0};
        tt[2] = '{a: 1'b0, b: 1'b1, s: 1'b1, c: 1'b0};
        tt[3] = '{a: 1'b1, b: 1'b1, s: 1'b0, c: 1'b1};

        rst_n = 1'b0;
        a1 = '0; b1 = '0;
        a4 = '0; b4 = '0;
        a8 = '0; b8 = '0;

        // Combinational truth table at WIDTH=1, one time unit per vector.
        for (int i = 0; i < 4; i++) begin
            a1 = tt[i].a;
            b1 = tt[i].b;
            #1;
            check($sformatf("tt%0d_s", i), 64'(s1), 64'(tt[i].s));
            check($sformatf("tt%0d_c", i), 64'(c1), 64'(tt[i].c));
        end

        // Reset held with a=b=1: combinational outputs live, registers zero.
        a1 = 1'b1; b1 = 1'b1;
        #1;
        check("rst_comb_s", 64'(s1), 64'd0);
        check("rst_comb_c", 64'(c1), 64'd1);
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("rst_sq_%0d", k), 64'(s_q1), 64'd0);
            check($sformatf("rst_cq_%0d", k), 64'(c_q1), 64'd0);
            check($sformatf("rst_cq4_%0d", k), 64'(c_q4), 64'd0);
            check($sformatf("rst_sq8_%0d", k), 64'(s_q8), 64'd0);
        end
        check("rst_hold_c", 64'(c1), 64'd1);

        // Release: first edge with rst_n=1 captures the current inputs.
        rst_n = 1'b1;
        a1 = 1'b1; b1 = 1'b0;
        #1;
        check("rel_early_sq", 64'(s_q1), 64'd0);
        check("rel_comb_s", 64'(s1), 64'd1);
        tick();
        check("rel_sq", 64'(s_q1), 64'd1);
        check("rel_cq", 64'(c_q1), 64'd0);

        // Four independent lanes, no carry between them.
        a4 = 4'b1100; b4 = 4'b1010;
        #1;
        check("w4_s", 64'(s4), 64'(4'b0110));
        check("w4_c", 64'(c4), 64'(4'b1000));
        check("w4_sq_early", 64'(s_q4), 64'd0);
        tick();
        check("w4_sq", 64'(s_q4), 64'(4'b0110));
        check("w4_cq", 64'(c_q4), 64'(4'b1000));

        // Random WIDTH=8 stream through a scoreboard, one reset cycle mid-stream.
        for (int i = 0; i < 1000; i++) begin
            if (i > 0) begin
                if (sb_q.size() == 0) begin
                    check($sformatf("sb_empty_%0d", i), 64'd0, 64'd1);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("rnd_sq_%0d", i), 64'(s_q8), 64'(e.s));
                    check($sformatf("rnd_cq_%0d", i), 64'(c_q8), 64'(e.c));
                end
            end
            rst_n = (i == 500) ? 1'b0 : 1'b1;
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            #1;
            check($sformatf("rnd_s_%0d", i), 64'(s8), 64'(a8 ^ b8));
            check($sformatf("rnd_c_%0d", i), 64'(c8), 64'(a8 & b8));
            check($sformatf("rnd_sc_%0d", i), 64'(s8 & c8), 64'd0);
            if (rst_n) begin
                e.s = a8 ^ b8;
                e.c = a8 & b8;
            end else begin
                e.s = '0;
                e.c = '0;
            end
            sb_q.push_back(e);
            tick();
        end
        if (sb_q.size() == 0) begin
            check("sb_final_empty", 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check("rnd_sq_last", 64'(s_q8), 64'(e.s));
            check("rnd_cq_last", 64'(c_q8), 64'(e.c));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_half_adder_gate_level
